// File: rtl/hmem_arb.sv
// hmem_arb: round-robin arbiter of NCH line-wide requester channels onto one upstream port,
// broadcasting a one-cycle invalidate for every completed write.
module hmem_arb #(
  parameter int NCH    = 2,
  parameter int LINE   = 256,
  parameter int ADDR_W = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NCH*ADDR_W-1:0] b_addr,
  input  logic [NCH*LINE-1:0]   b_data_out,
  input  logic [NCH-1:0]        b_rd,
  input  logic [NCH-1:0]        b_wr,
  output logic [LINE-1:0]       b_data_in,
  output logic [NCH-1:0]        b_dv,
  output logic [ADDR_W-1:0]     h_addr,
  output logic [LINE-1:0]       h_data_out,
  output logic                  h_rd,
  output logic                  h_wr,
  input  logic [LINE-1:0]       h_data_in,
  input  logic                  h_dv,
  output logic [ADDR_W-1:0]     inv_addr,
  output logic                  inv
);
  localparam int CW  = $clog2(NCH);
  localparam int OFF = $clog2(LINE / 8);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t            r_state, w_next;
  logic [CW-1:0]     r_rr, r_gnt, w_sel;
  logic [NCH-1:0]    r_mask, w_elig, w_gnt_oh;
  logic              w_found, r_op;
  logic [ADDR_W-1:0] r_addr, w_raddr;
  logic [LINE-1:0]   r_wdata, r_rdata;
  assign w_elig   = (b_rd | b_wr) & ~r_mask;
  assign w_raddr  = b_addr[int'(w_sel)*ADDR_W +: ADDR_W];
  assign w_gnt_oh = NCH'(1) << r_gnt;
  // first eligible channel at or after the round-robin pointer
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    for (int i = 0; i < NCH; i++) begin
      if (!w_found && w_elig[(int'(r_rr) + i) % NCH]) begin
        w_found = 1'b1;
        w_sel   = CW'((int'(r_rr) + i) % NCH);
      end
    end
  end
  always_comb begin
    w_next = r_state;
    w_next = (r_state == IDLE) ? (w_found ? BUSY : IDLE) :
             (r_state == BUSY) ? (h_dv ? DONE : BUSY) : IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr    <= '0;
      r_gnt   <= '0;
      r_mask  <= '0;
      r_op    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else begin
      if (r_state == IDLE) begin
        r_mask <= '0;
        if (w_found) begin
          r_gnt   <= w_sel;
          r_op    <= b_wr[w_sel];
          r_addr  <= {w_raddr[ADDR_W-1:OFF], {OFF{1'b0}}};
          r_wdata <= b_data_out[int'(w_sel)*LINE +: LINE];
        end
      end
      if (r_state == BUSY && h_dv && !r_op) r_rdata <= h_data_in;
      if (r_state == DONE) begin
        r_rr   <= (r_gnt == CW'(NCH - 1)) ? '0 : r_gnt + CW'(1);
        r_mask <= w_gnt_oh;
      end
    end
  end
  assign h_rd       = (r_state == BUSY) && !r_op;
  assign h_wr       = (r_state == BUSY) && r_op;
  assign h_addr     = r_addr;
  assign h_data_out = r_wdata;
  assign b_data_in  = r_rdata;
  assign b_dv       = (r_state == DONE) ? w_gnt_oh : '0;
  assign inv        = (r_state == DONE) && r_op;
  assign inv_addr   = inv ? r_addr : '0;
endmodule

// File: tb/tb_hmem_arb.sv
// tb_hmem_arb: directed vector table plus hand-written sequences for reset, fairness, masking.
module tb_hmem_arb;
  localparam int NCH = 3, LINE = 256, AW = 64;
  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NCH*AW-1:0] b_addr = '0;
  logic [NCH*LINE-1:0] b_data_out = '0;
  logic [NCH-1:0]    b_rd = '0, b_wr = '0;
  logic [LINE-1:0]   b_data_in;
  logic [NCH-1:0]    b_dv;
  logic [AW-1:0]     h_addr, inv_addr;
  logic [LINE-1:0]   h_data_out;
  logic              h_rd, h_wr, inv;
  logic [LINE-1:0]   h_data_in = '0;
  logic              h_dv = 1'b0;
  int n_vec = 0, n_bad = 0;

  hmem_arb #(.NCH(NCH), .LINE(LINE), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .b_addr(b_addr), .b_data_out(b_data_out),
    .b_rd(b_rd), .b_wr(b_wr), .b_data_in(b_data_in), .b_dv(b_dv),
    .h_addr(h_addr), .h_data_out(h_data_out), .h_rd(h_rd), .h_wr(h_wr),
    .h_data_in(h_data_in), .h_dv(h_dv), .inv_addr(inv_addr), .inv(inv)
  );

  always #5 clk = ~clk;

  typedef struct {
    int ch; logic rd; logic wr;
    logic [AW-1:0] addr; logic [LINE-1:0] wdata; logic [LINE-1:0] rdata; int lat;
    logic [AW-1:0] haddr; logic inv; logic [LINE-1:0] bdin;
  } vec_t;
  vec_t vecs[5];

  task automatic chk(input string name, input logic [LINE-1:0] act, input logic [LINE-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_req(output int cyc);
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (!(h_rd || h_wr) && cyc < 20);
    chk("req_seen", LINE'(h_rd | h_wr), 1);
  endtask

  task automatic run_txn(input vec_t v);
    int cyc;
    @(posedge clk); #1;
    b_addr[v.ch*AW +: AW] = v.addr;
    b_data_out[v.ch*LINE +: LINE] = v.wdata;
    b_rd = '0; b_wr = '0;
    b_rd[v.ch] = v.rd;
    b_wr[v.ch] = v.wr;
    wait_req(cyc);
    chk("req_latency", LINE'(cyc), 2);
    chk("h_addr", LINE'(h_addr), LINE'(v.haddr));
    chk("h_rd_h_wr", LINE'({h_rd, h_wr}), LINE'({v.rd & ~v.wr, v.wr}));
    if (v.wr) chk("h_data_out", h_data_out, v.wdata);
    repeat (v.lat) @(posedge clk);
    #1 h_dv = 1'b1; h_data_in = v.rdata;
    @(posedge clk); #1 h_dv = 1'b0;
    @(negedge clk);
    chk("b_dv", LINE'(b_dv), LINE'(3'b001 << v.ch));
    chk("inv", LINE'(inv), LINE'(v.inv));
    if (v.inv) chk("inv_addr", LINE'(inv_addr), LINE'(v.haddr));
    chk("b_data_in", b_data_in, v.bdin);
    chk("h_req_dropped", LINE'({h_rd, h_wr}), 0);
    @(posedge clk); #1 b_rd = '0; b_wr = '0;
    @(negedge clk);
    chk("after_done", LINE'({b_dv, inv}), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int cyc;
    logic [AW-1:0] rr_addr[NCH];
    vecs[0] = '{1, 1'b1, 1'b0, 64'h1234_5678, 256'h0, {32{8'hA5}}, 2,
                64'h1234_5660, 1'b0, {32{8'hA5}}};
    vecs[1] = '{0, 1'b0, 1'b1, 64'h8000_0044, {8{32'hDEADBEEF}}, {32{8'h5A}}, 1,
                64'h8000_0040, 1'b1, {32{8'hA5}}};
    vecs[2] = '{2, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, {16{16'hC0DE}}, {32{8'h3C}}, 1,
                64'hFFFF_FFFF_FFFF_FFE0, 1'b1, {32{8'hA5}}};
    vecs[3] = '{2, 1'b1, 1'b0, 64'h20, 256'h0, {4{64'h0123_4567_89AB_CDEF}}, 3,
                64'h20, 1'b0, {4{64'h0123_4567_89AB_CDEF}}};
    vecs[4] = '{0, 1'b1, 1'b0, 64'h1F, 256'h0, 256'h1, 1,
                64'h0, 1'b0, 256'h1};
    rr_addr[0] = 64'h1000; rr_addr[1] = 64'h2010; rr_addr[2] = 64'h3025;
    for (int k = 0; k < NCH; k++) b_addr[k*AW +: AW] = rr_addr[k];
    b_rd = 3'b111;
    repeat (3) @(negedge clk);
    chk("rst_ctrl", LINE'({b_dv, h_rd, h_wr, inv}), 0);
    chk("rst_h_addr", LINE'(h_addr), 0);
    chk("rst_inv_addr", LINE'(inv_addr), 0);
    chk("rst_b_data_in", b_data_in, 0);
    chk("rst_h_data_out", h_data_out, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      wait_req(cyc);
      chk("rr_h_addr", LINE'(h_addr), LINE'(rr_addr[k % NCH] & ~64'h1F));
      @(posedge clk); #1 h_dv = 1'b1;
      @(posedge clk); #1 h_dv = 1'b0;
      @(negedge clk);
      chk("rr_b_dv", LINE'(b_dv), LINE'(3'b001 << (k % NCH)));
    end
    @(posedge clk); #1 b_rd = '0;
    @(negedge clk);
    foreach (vecs[i]) run_txn(vecs[i]);
    @(posedge clk); #1;
    b_addr[2*AW +: AW] = 64'h4000;
    b_rd = 3'b100;
    wait_req(cyc);
    @(posedge clk); #1 h_dv = 1'b1;
    @(posedge clk); #1 h_dv = 1'b0;
    @(negedge clk);
    chk("mask_b_dv", LINE'(b_dv), 3'b100);
    @(posedge clk);
    @(posedge clk); #1 b_rd = '0;
    @(negedge clk);
    chk("mask_no_dup", LINE'({h_rd, h_wr}), 0);
    repeat (2) begin
      @(negedge clk);
      chk("mask_quiet", LINE'({b_dv, h_rd, h_wr}), 0);
    end
    run_txn('{2, 1'b1, 1'b0, 64'h4000, 256'h0, {8{32'hCAFEF00D}}, 1,
              64'h4000, 1'b0, {8{32'hCAFEF00D}}});
    @(posedge clk); #1;
    b_addr[1*AW +: AW] = 64'h5000;
    b_rd = 3'b010;
    wait_req(cyc);
    rst_n = 1'b0;
    #1;
    chk("rst_busy_h_rd", LINE'(h_rd), 0);
    chk("rst_busy_b_data_in", b_data_in, 0);
    b_rd = '0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1 h_dv = 1'b1; h_data_in = {32{8'h77}};
    @(posedge clk); #1 h_dv = 1'b0;
    @(negedge clk);
    chk("idle_hdv_ignored", LINE'({b_dv, h_rd, h_wr, inv}), 0);
    @(negedge clk);
    chk("idle_hdv_ignored2", LINE'({b_dv, inv}), 0);
    chk("idle_hdv_no_capture", b_data_in, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/hmem_arb.md
Name: hmem_arb

Overview:
Parametrised successor to the two-port (I/D) hierarchy memory interface. Arbitrates NCH requester channels (cache refill/writeback ports) onto one upstream line-wide port with round-robin fairness. Broadcasts a one-cycle invalidate for every completed write so peer caches drop stale lines. Sits between the L1 caches and the next memory level.

Parameters:
NCH, 2, number of requester channels (>=2)
LINE, 256, line width in bits, requester and upstream (power of two, >=64)
ADDR_W, 64, address width

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
b_addr  in  NCH*ADDR_W  per-channel request address, channel k at [k*ADDR_W +: ADDR_W]
b_data_out  in  NCH*LINE  per-channel write data, channel k at [k*LINE +: LINE]
b_rd  in  NCH  per-channel read request (level)
b_wr  in  NCH  per-channel write request (level)
b_data_in  out  LINE  read return data, shared by all channels
b_dv  out  NCH  per-channel completion pulse
h_addr  out  ADDR_W  upstream line-aligned address
h_data_out  out  LINE  upstream write data
h_rd  out  1  upstream read request
h_wr  out  1  upstream write request
h_data_in  in  LINE  upstream read data
h_dv  in  1  upstream completion
inv_addr  out  ADDR_W  invalidate address (line-aligned)
inv  out  1  invalidate pulse

Behaviour:
- Reset (async, rst_n=0): b_dv=0, b_data_in=0, h_rd=h_wr=0, h_addr=0, h_data_out=0, inv=0, inv_addr=0, state IDLE, rr pointer=0, mask clear. Any in-flight transaction is abandoned; upstream must accept h_rd/h_wr dropping.
- Request: channel k is pending if b_rd[k]|b_wr[k]. Requester holds addr/data/request stable until b_dv[k] and deasserts the cycle after it. b_rd and b_wr together: treated as write.
- FSM: IDLE, BUSY, DONE.
- IDLE: eligible = pending & ~mask. If any eligible, grant the first eligible index at or after rr pointer (wrapping modulo NCH). Latch gnt, op, address with low log2(LINE/8) bits cleared, and write data. Go to BUSY. Clear mask. If none eligible, stay in IDLE and clear mask.
- BUSY: h_rd=(op==rd), h_wr=(op==wr), h_addr and h_data_out from latches, all registered, so they assert in the first BUSY cycle. Wait for h_dv. h_dv is sampled only in BUSY; in IDLE or DONE it is ignored. On h_dv: drop h_rd/h_wr next cycle and go to DONE. For a read, capture h_data_in into b_data_in.
- DONE (exactly 1 cycle): b_dv[gnt]=1, all other b_dv bits 0. For a write: inv=1, inv_addr=latched aligned address, same cycle. rr pointer <= (gnt+1) mod NCH. mask <= one-hot gnt. Go to IDLE.
- Mask: excludes the just-served channel in the following IDLE cycle only, which covers its request-drop cycle.
- Latency: request visible in IDLE cycle t -> h_rd/h_wr at t+1. h_dv at cycle n -> b_dv at n+1. Minimum request-to-b_dv latency is 3 cycles. Back-to-back throughput is one transaction per 3+upstream cycles.
- b_data_in holds its last captured value outside DONE. It is unchanged by writes. Only one b_dv bit is ever high, and only in DONE.
- Fairness: with all channels pending continuously, grants cycle 0,1,...,NCH-1,0.
- inv is never asserted for reads. The invalidate also reaches the writing channel, and that channel ignores it.

Test Plan:
- Reset: NCH=3, drive all requests with rst_n=0 -> all outputs 0. Release reset -> first grant goes to ch0.
- Single read: ch1 b_rd=1, b_addr=0x1234_5678. h_addr=0x1234_5660 (LINE=256). Return h_dv with h_data_in=0xA5..A5 two cycles after h_rd -> b_dv=3'b010 for 1 cycle, b_data_in=0xA5..A5, inv=0.
- Write with invalidate: ch0 b_wr=1, addr 0x8000_0044, data 0xDEAD... -> h_wr=1, h_addr=0x8000_0040, h_data_out=0xDEAD.... On h_dv -> b_dv=3'b001 and inv=1 with inv_addr=0x8000_0040 in the same cycle.
- Round-robin: NCH=3, all channels request continuously, upstream h_dv one cycle after request -> grant order 0,1,2,0,1,2, no channel served twice consecutively.
- Mask/drop: ch2 alone requests and holds b_rd one extra cycle after b_dv -> no duplicate grant in that IDLE cycle. Re-request later is served normally.
- Reset mid-BUSY: assert rst_n=0 while h_rd=1 -> h_rd drops immediately. After release, a later h_dv pulse in IDLE is ignored, giving no b_dv.
